// File: rtl/riscv_alu.sv
// RV32I register-register ALU: combinational op/flag datapath feeding
// result and ONZC flag registers, giving a fixed one-cycle latency.
module riscv_alu #(
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] A,
    input  logic [REG_BITS-1:0] B,
    input  logic [3:0]          ctrl,
    output logic [REG_BITS-1:0] C,
    output logic [3:0]          ONZC
);

    localparam int SH_W = (REG_BITS > 1) ? $clog2(REG_BITS) : 1;
    localparam int MSB  = REG_BITS - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001
    } alu_op_e;

    logic signed [REG_BITS-1:0] a_s;
    logic signed [REG_BITS-1:0] b_s;
    logic        [REG_BITS-1:0] b_op;
    logic        [REG_BITS:0]   sum_full;
    logic        [REG_BITS-1:0] sum;
    logic        [SH_W-1:0]     shamt;
    logic                       sh_big;
    logic                       is_sub;
    logic        [REG_BITS-1:0] c_d;
    logic        [REG_BITS-1:0] c_q;
    logic        [3:0]          onzc_d;
    logic        [3:0]          onzc_q;
    logic                       ovf;
    logic                       cout;

    always_comb begin
        a_s      = A;
        b_s      = B;
        is_sub   = (ctrl == OP_SUB);
        // One adder serves both ADD and SUB; SUB feeds ~B with carry-in 1.
        b_op     = is_sub ? ~B : B;
        sum_full = {1'b0, A} + {1'b0, b_op} + {{REG_BITS{1'b0}}, is_sub};
        sum      = sum_full[MSB:0];
        shamt    = B[SH_W-1:0];
        sh_big   = (32'(shamt) >= 32'(REG_BITS));

        c_d  = '0;
        ovf  = 1'b0;
        cout = 1'b0;
        case (ctrl)
            OP_ADD: begin
                c_d  = sum;
                cout = sum_full[REG_BITS];
                ovf  = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                c_d  = sum;
                cout = sum_full[REG_BITS];
                ovf  = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_AND:  c_d = A & B;
            OP_OR:   c_d = A | B;
            OP_XOR:  c_d = A ^ B;
            OP_SLT:  c_d = {{(REG_BITS-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: c_d = {{(REG_BITS-1){1'b0}}, (A < B)};
            OP_SLL:  c_d = sh_big ? '0 : (A << shamt);
            OP_SRL:  c_d = sh_big ? '0 : (A >> shamt);
            OP_SRA:  c_d = sh_big ? {REG_BITS{A[MSB]}} : REG_BITS'(a_s >>> shamt);
            default: c_d = '0;
        endcase

        onzc_d = {ovf, c_d[MSB], (c_d == '0), cout};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q    <= '0;
            onzc_q <= '0;
        end else begin
            c_q    <= c_d;
            onzc_q <= onzc_d;
        end
    end

    assign C    = c_q;
    assign ONZC = onzc_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed bench for riscv_alu (REG_BITS=5) with an expected-result queue.
module tb_riscv_alu;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ctrl;
    logic [W-1:0] C;
    logic [3:0]   ONZC;

    typedef struct {
        string        tag;
        logic [W-1:0] c;
        logic [3:0]   f;
    } exp_t;

    exp_t exp_q[$];
    int   applied;
    int   miscompares;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           XOR_ = 4'b0100, SLT = 4'b0101, SLL = 4'b0110, SLTU = 4'b0111,
                           SRL = 4'b1000, SRA = 4'b1001;

    riscv_alu #(.REG_BITS(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .ctrl (ctrl),
        .C    (C),
        .ONZC (ONZC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] op,
                        input logic [W-1:0] ec, input logic [3:0] ef);
        exp_t e;
        exp_t got;
        rst_n = rn;
        A     = a;
        B     = b;
        ctrl  = op;
        e.tag = tag;
        e.c   = ec;
        e.f   = ef;
        exp_q.push_back(e);
        applied++;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        assert ((C === got.c) && (ONZC === got.f))
        else begin
            miscompares++;
            $error("FAIL %s: got C=%b ONZC=%b, expected C=%b ONZC=%b",
                   got.tag, C, ONZC, got.c, got.f);
        end
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        A     = '0;
        B     = '0;
        ctrl  = ADD;
        @(negedge clk);

        step("reset",        1'b0, 5'b00101, 5'b00101, ADD,  5'b00000, 4'b0000);
        step("add_5_5",      1'b1, 5'b00101, 5'b00101, ADD,  5'b01010, 4'b0000);
        step("add_neg",      1'b1, 5'b11110, 5'b00001, ADD,  5'b11111, 4'b0100);
        step("add_carry",    1'b1, 5'b11110, 5'b00010, ADD,  5'b00000, 4'b0011);
        step("add_ovf",      1'b1, 5'b01111, 5'b00010, ADD,  5'b10001, 4'b1100);
        step("sub",          1'b1, 5'b01111, 5'b00010, SUB,  5'b01101, 4'b0001);
        step("sub_ovf",      1'b1, 5'b10000, 5'b00001, SUB,  5'b01111, 4'b1001);
        step("sub_borrow",   1'b1, 5'b00001, 5'b00010, SUB,  5'b11111, 4'b0100);
        step("and",          1'b1, 5'b01111, 5'b00010, AND_, 5'b00010, 4'b0000);
        step("or",           1'b1, 5'b01111, 5'b00001, OR_,  5'b01111, 4'b0000);
        step("xor",          1'b1, 5'b01111, 5'b00001, XOR_, 5'b01110, 4'b0000);
        step("slt_0_1",      1'b1, 5'b00000, 5'b00001, SLT,  5'b00001, 4'b0000);
        step("slt_0_m1",     1'b1, 5'b00000, 5'b11111, SLT,  5'b00000, 4'b0010);
        step("sltu_26_1",    1'b1, 5'b11010, 5'b00001, SLTU, 5'b00000, 4'b0010);
        step("sltu_1_26",    1'b1, 5'b00001, 5'b11010, SLTU, 5'b00001, 4'b0000);
        step("slt_min_max",  1'b1, 5'b10000, 5'b01111, SLT,  5'b00001, 4'b0000);
        step("sll",          1'b1, 5'b11010, 5'b00001, SLL,  5'b10100, 4'b0100);
        step("srl",          1'b1, 5'b11010, 5'b00001, SRL,  5'b01101, 4'b0000);
        step("sra_1",        1'b1, 5'b10000, 5'b00001, SRA,  5'b11000, 4'b0100);
        step("sra_big",      1'b1, 5'b10000, 5'b00111, SRA,  5'b11111, 4'b0100);
        step("srl_big",      1'b1, 5'b10000, 5'b00111, SRL,  5'b00000, 4'b0010);
        step("sll_big",      1'b1, 5'b00001, 5'b00110, SLL,  5'b00000, 4'b0010);
        step("sll_hi_b_ign", 1'b1, 5'b00001, 5'b11010, SLL,  5'b00100, 4'b0000);
        step("rsv_1111",     1'b1, 5'b01111, 5'b00011, 4'b1111, 5'b00000, 4'b0010);
        step("rsv_1010",     1'b1, 5'b11111, 5'b11111, 4'b1010, 5'b00000, 4'b0010);
        step("mid_reset",    1'b0, 5'b00101, 5'b00101, ADD,  5'b00000, 4'b0000);
        step("after_reset",  1'b1, 5'b00101, 5'b00101, ADD,  5'b01010, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
